// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: ALU results win over buffered cache load returns,
// with a pending-load scoreboard exported to the issue stage.
module wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_wa,
  input  logic [WIDTH-1:0]         alu_wd,
  input  logic                     ld_issue,
  input  logic [4:0]               ld_issue_wa,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [4:0]               ld_wa,
  input  logic [WIDTH-1:0]         ld_wd,
  output logic                     we,
  output logic [4:0]               wa,
  output logic [WIDTH-1:0]         wd,
  output logic [31:0]              pend,
  output logic [$clog2(DEPTH):0]   buf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [4:0]       buf_wa [DEPTH];
  logic [WIDTH-1:0] buf_wd [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             push;
  logic             pop;
  logic [4:0]       head_wa;
  logic [WIDTH-1:0] head_wd;
  logic [31:0]      pend_nxt;

  // Ready depends on occupancy only, so a full buffer refuses data even while popping.
  assign ld_ready = (buf_cnt < CNT_FULL);
  assign push     = ld_valid && ld_ready;
  assign pop      = !alu_valid && (buf_cnt != '0);
  assign head_wa  = buf_wa[head];
  assign head_wd  = buf_wd[head];

  always_ff @(posedge clk) begin
    if (push) begin
      buf_wa[tail] <= ld_wa;
      buf_wd[tail] <= ld_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      buf_cnt <= '0;
    end else begin
      if (push) tail <= tail + PTR_ONE;
      if (pop)  head <= head + PTR_ONE;
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + CNT_ONE;
        2'b01:   buf_cnt <= buf_cnt - CNT_ONE;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // A set from a newly issued load overrides the clear from an older load's writeback.
  always_comb begin
    pend_nxt = pend;
    if (pop && (head_wa != 5'd0)) pend_nxt[head_wa] = 1'b0;
    if (ld_issue && (ld_issue_wa != 5'd0)) pend_nxt[ld_issue_wa] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else if (alu_valid) begin
      we <= (alu_wa != 5'd0);
      wa <= alu_wa;
      wd <= alu_wd;
    end else if (pop) begin
      we <= (head_wa != 5'd0);
      wa <= head_wa;
      wd <= head_wd;
    end else begin
      we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, then random traffic,
// all compared every cycle against a queue-based model of the writeback rules.
module tb_wb_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             alu_valid;
  logic [4:0]       alu_wa;
  logic [WIDTH-1:0] alu_wd;
  logic             ld_issue;
  logic [4:0]       ld_issue_wa;
  logic             ld_valid;
  logic             ld_ready;
  logic [4:0]       ld_wa;
  logic [WIDTH-1:0] ld_wd;
  logic             we;
  logic [4:0]       wa;
  logic [WIDTH-1:0] wd;
  logic [31:0]      pend;
  logic [$clog2(DEPTH):0] buf_cnt;

  wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .ld_issue(ld_issue), .ld_issue_wa(ld_issue_wa),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wa(ld_wa), .ld_wd(ld_wd),
    .we(we), .wa(wa), .wd(wd), .pend(pend), .buf_cnt(buf_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]       a;
    logic [WIDTH-1:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pend = '0;
  logic        m_we   = 1'b0;
  logic [4:0]  m_wa   = '0;
  logic [31:0] m_wd   = '0;
  bit          m_init = 0;
  bit          m_accept = 0;

  // Reference: one write per cycle, ALU first, else oldest accepted load.
  always @(posedge clk) begin
    bit   rdy;
    ent_t e;
    m_init   = 1;
    m_accept = 0;
    if (rst) begin
      q.delete();
      m_pend = '0;
      m_we   = 1'b0;
      m_wa   = '0;
      m_wd   = '0;
    end else begin
      rdy = (q.size() < DEPTH);
      if (alu_valid) begin
        m_we = (alu_wa != 0);
        m_wa = alu_wa;
        m_wd = alu_wd;
      end else if (q.size() > 0) begin
        e    = q.pop_front();
        m_we = (e.a != 0);
        m_wa = e.a;
        m_wd = e.d;
        if (e.a != 0) m_pend[e.a] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (ld_issue && ld_issue_wa != 0) m_pend[ld_issue_wa] = 1'b1;
      if (ld_valid && rdy) begin
        q.push_back('{ld_wa, ld_wd});
        m_accept = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("we", {31'd0, we}, {31'd0, m_we});
      if (m_we) begin
        chk("wa", {27'd0, wa}, {27'd0, m_wa});
        chk("wd", wd, m_wd);
      end
      chk("pend", pend, m_pend);
      chk("buf_cnt", 32'(buf_cnt), 32'(q.size()));
      chk("ld_ready", {31'd0, ld_ready}, {31'd0, (q.size() < DEPTH)});
    end
  end

  task automatic idle();
    alu_valid = 0; alu_wa = '0; alu_wd = '0;
    ld_issue = 0; ld_issue_wa = '0;
    ld_valid = 0; ld_wa = '0; ld_wd = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1;
    ld_valid = 1; ld_wa = 5'd3; ld_wd = 32'hAAAA_0003;
    step(); step();
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_pend", pend, 32'd0);
    chk("rst_cnt", 32'(buf_cnt), 32'd0);
    chk("rst_ready", {31'd0, ld_ready}, 32'd1);
    rst = 0;
    idle();

    // ALU only
    alu_valid = 1; alu_wa = 5'd5; alu_wd = 32'h1234_5678;
    step();
    chk("alu_we", {31'd0, we}, 32'd1);
    chk("alu_wa", {27'd0, wa}, 32'd5);
    chk("alu_wd", wd, 32'h1234_5678);
    idle();
    step();
    chk("alu_idle_we", {31'd0, we}, 32'd0);

    // Load path and scoreboard
    ld_issue = 1; ld_issue_wa = 5'd7;
    step();
    chk("pend7_set", {31'd0, pend[7]}, 32'd1);
    idle();
    ld_valid = 1; ld_wa = 5'd7; ld_wd = 32'hDEAD_BEEF;
    step();
    chk("ld_push_cnt", 32'(buf_cnt), 32'd1);
    chk("ld_push_we", {31'd0, we}, 32'd0);
    idle();
    step();
    chk("ld_we", {31'd0, we}, 32'd1);
    chk("ld_wa", {27'd0, wa}, 32'd7);
    chk("ld_wd", wd, 32'hDEAD_BEEF);
    chk("pend7_clr", {31'd0, pend[7]}, 32'd0);

    // Collision and full
    alu_valid = 1; alu_wa = 5'd10; alu_wd = 32'h10;
    ld_valid = 1; ld_wa = 5'd1; ld_wd = 32'h101;
    step();
    alu_wa = 5'd11; ld_wa = 5'd2; ld_wd = 32'h102;
    step();
    alu_wa = 5'd12; ld_wa = 5'd3; ld_wd = 32'h103;
    step();
    alu_wa = 5'd13;
    step();
    chk("full_cnt", 32'(buf_cnt), 32'd2);
    chk("full_ready", {31'd0, ld_ready}, 32'd0);
    chk("full_alu_wa", {27'd0, wa}, 32'd13);
    alu_valid = 0;
    step();
    chk("drain1_wa", {27'd0, wa}, 32'd1);
    chk("drain1_we", {31'd0, we}, 32'd1);
    chk("drain1_cnt", 32'(buf_cnt), 32'd1);
    step();
    chk("drain2_wa", {27'd0, wa}, 32'd2);
    chk("drain2_cnt", 32'(buf_cnt), 32'd1);
    ld_valid = 0;
    step();
    chk("drain3_wa", {27'd0, wa}, 32'd3);
    chk("drain3_wd", wd, 32'h103);
    chk("drain3_cnt", 32'(buf_cnt), 32'd0);
    idle();

    // Set/clear race on reg 9
    ld_issue = 1; ld_issue_wa = 5'd9;
    step();
    ld_issue = 0;
    alu_valid = 1; alu_wa = 5'd20; alu_wd = 32'h20;
    ld_valid = 1; ld_wa = 5'd9; ld_wd = 32'h909;
    step();
    idle();
    ld_issue = 1; ld_issue_wa = 5'd9;
    step();
    chk("race_we", {31'd0, we}, 32'd1);
    chk("race_wa", {27'd0, wa}, 32'd9);
    chk("race_pend9", {31'd0, pend[9]}, 32'd1);
    idle();

    // x0 handling
    alu_valid = 1; alu_wa = 5'd0; alu_wd = 32'hFFFF_0000;
    ld_valid = 1; ld_wa = 5'd0; ld_wd = 32'h0000_FFFF;
    step();
    chk("x0_alu_we", {31'd0, we}, 32'd0);
    chk("x0_cnt1", 32'(buf_cnt), 32'd1);
    idle();
    ld_issue = 1; ld_issue_wa = 5'd0;
    step();
    chk("x0_ld_we", {31'd0, we}, 32'd0);
    chk("x0_cnt0", 32'(buf_cnt), 32'd0);
    chk("x0_pend0", {31'd0, pend[0]}, 32'd0);
    idle();

    // Random traffic with a well-behaved cache (holds data until accepted)
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 299) == 0);
      alu_valid = ($urandom_range(0, 99) < 55);
      alu_wa = 5'($urandom_range(0, 31));
      alu_wd = $urandom;
      ld_issue = ($urandom_range(0, 99) < 30);
      ld_issue_wa = 5'($urandom_range(0, 31));
      if (!ld_valid || m_accept) begin
        ld_valid = ($urandom_range(0, 99) < 60);
        ld_wa = 5'($urandom_range(0, 31));
        ld_wd = $urandom;
      end
    end
    idle();
    rst = 0;
    step(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
